// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one async_transmitter among NUM_REQ byte sources,
// with packet locking and a timeout when the transmitter never reports busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 err_timeout
);

  localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               active_q, active_d;
  logic               err_q, err_d;

  logic [7:0]  valid_pad, last_pad, onehot;
  logic [63:0] data_pad;
  logic        win_found;
  logic [2:0]  win_idx, scan_idx;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  // Inputs are zero-padded to 8 requesters so 3-bit indices never select out of range.
  always_comb begin
    valid_pad = 8'(req_valid);
    last_pad  = 8'(req_last);
    data_pad  = 64'(req_data);
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    if (lock_q) begin
      win_found = valid_pad[grant_id_q];
      win_idx   = grant_id_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!win_found && valid_pad[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
        scan_idx = next_idx(scan_idx);
      end
    end
    onehot = 8'd1 << win_idx;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          state_d     = WAIT_BUSY;
          req_ready_d = onehot[NUM_REQ-1:0];
          tx_start_d  = 1'b1;
          tx_data_d   = data_pad[{win_idx, 3'b000} +: 8];
          grant_id_d  = win_idx;
          lock_d      = ~last_pad[win_idx];
          cnt_d       = '0;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // Byte is dropped; the packet lock is released so others are not starved.
          state_d  = IDLE;
          err_d    = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = next_idx(grant_id_q);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (!lock_q) rr_ptr_d = next_idx(grant_id_q);
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level reference model predicts the
// grant sequence; a monitor checks every tx_start against it.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  typedef struct packed {logic [7:0] data; logic last;} byte_t;
  typedef struct packed {logic [2:0] id; logic [7:0] data;} exp_t;
  typedef struct packed {logic timeout; logic longb;} resp_t;

  logic           clk, rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, active, err_timeout;
  logic [7:0]     tx_data;
  logic [2:0]     grant_id;

  logic stall_req, stall_r, rsp_busy, rsp_act;
  logic [N-1:0] en;

  byte_t       pend [N][64];
  int unsigned head [N];
  int unsigned tail [N];
  int unsigned ntail[N];

  exp_t  exp_q [$];
  resp_t resp_q[$];

  int n_vec = 0, n_mis = 0;
  int n_starts = 0, n_ready = 0, n_err = 0;
  int m_ptr = 0, m_lock_id = 0;
  bit m_lock = 0;

  assign tx_busy = stall_r | rsp_busy;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_drained();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 0;
    return 1;
  endfunction

  // Requesters: present the head byte while enabled, advance on req_ready.
  initial begin
    for (int i = 0; i < N; i++) head[i] = 0;
    req_valid = '0; req_data = '0; req_last = '0; stall_r = 0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && head[i] != tail[i]) head[i]++;
      for (int i = 0; i < N; i++) begin
        if (en[i] && head[i] != tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = pend[i][head[i] % 64].data;
          req_last[i]        = pend[i][head[i] % 64].last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      stall_r = stall_req;
    end
  end

  // Transmitter model: raises busy after a short delay, or stays silent for a timeout.
  initial begin
    resp_t r;
    int d, l, c;
    bit found;
    rsp_busy = 0; rsp_act = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_start && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        rsp_act = 1;
        if (r.timeout) begin
          c = 0; found = 0;
          for (int k = 1; k <= 24 && !found; k++) begin
            @(posedge clk); #1;
            if (err_timeout) begin found = 1; c = k; end
          end
          chk("timeout_latency", c, TMO);
        end else begin
          d = $urandom_range(3);
          repeat (d) begin @(posedge clk); #1; end
          rsp_busy = 1;
          l = r.longb ? 30 : $urandom_range(5, 1);
          repeat (l) begin @(posedge clk); #1; end
          rsp_busy = 0;
        end
        rsp_act = 0;
      end
    end
  end

  // Monitor: every tx_start must match the next predicted grant.
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(posedge clk); #1;
      if (err_timeout) n_err++;
      if (req_ready != '0) n_ready++;
      if (tx_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", {grant_id, tx_data}, 0);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[int'(e.id)] = 1'b1;
          chk("grant", {active, req_ready, grant_id, tx_data}, {1'b1, oh, e.id, e.data});
        end
      end else if (req_ready != '0) begin
        chk("stray_ready", req_ready, 0);
      end
    end
  end

  task automatic load(input int i, input logic [7:0] d, input logic l);
    pend[i][ntail[i] % 64] = '{data: d, last: l};
    ntail[i]++;
  endtask

  // Reference model: packet-level round robin over what is queued this round.
  task automatic model_round(input int tmo_pct, input bit tmo_first, input bit longb,
                             output int nb, output int ntmo);
    int unsigned mh[N];
    int left, w, j;
    byte_t b;
    exp_t e;
    resp_t r;
    left = 0; nb = 0; ntmo = 0;
    for (int i = 0; i < N; i++) begin
      mh[i] = head[i];
      left += int'(ntail[i] - head[i]);
    end
    while (left > 0) begin
      w = -1;
      if (m_lock) w = m_lock_id;
      else
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && mh[j] < ntail[j]) w = j;
        end
      if (w < 0 || mh[w] >= ntail[w]) begin
        $display("FAIL model_state: got locked requester %0d expected a pending byte", w);
        n_mis++;
        break;
      end
      b = pend[w][mh[w] % 64];
      mh[w]++; left--;
      e.id = 3'(w); e.data = b.data;
      r.longb = longb;
      r.timeout = tmo_first ? (nb == 0) : ($urandom_range(99) < tmo_pct);
      exp_q.push_back(e);
      resp_q.push_back(r);
      nb++;
      if (r.timeout) begin ntmo++; m_lock = 0; m_ptr = (w + 1) % N; end
      else if (b.last) begin m_lock = 0; m_ptr = (w + 1) % N; end
      else begin m_lock = 1; m_lock_id = w; end
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #2;
      if (!active && !tx_busy && !tx_start && !rsp_act && exp_q.size() == 0 &&
          resp_q.size() == 0 && all_drained()) done = 1;
    end
    if (!done) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic run_round(input int tmo_pct, input bit tmo_first, input bit longb, input bit do_rst);
    int nb, ntmo, e0;
    bit seen;
    wait_idle();
    @(negedge clk);
    model_round(tmo_pct, tmo_first, longb, nb, ntmo);
    for (int i = 0; i < N; i++) tail[i] = ntail[i];
    e0 = n_err;
    @(posedge clk);
    @(posedge clk); #2;
    if (nb > 0) chk("first_start_latency", tx_start, 1);
    if (do_rst) begin
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (tx_busy) seen = 1;
        else begin @(posedge clk); #2; end
      end
      chk("busy_before_reset", seen, 1);
      repeat (2) @(posedge clk);
      #3 rst_n = 0;
      #1 chk("async_reset_outputs", {req_ready, tx_start, tx_data, grant_id, active, err_timeout}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      m_ptr = 0; m_lock = 0;
    end
    wait_idle();
    chk("err_count", n_err - e0, ntmo);
  endtask

  initial begin
    int np, nbytes, s0, r0;
    rst_n = 0; stall_req = 0; en = '1;
    for (int i = 0; i < N; i++) begin tail[i] = 0; ntail[i] = 0; end
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {req_ready, tx_start, tx_data, grant_id, active, err_timeout}, 0);
    @(negedge clk) rst_n = 1;

    load(2, 8'h41, 1'b1);
    run_round(0, 0, 0, 0);

    load(1, 8'hA5, 1'b1);
    run_round(0, 0, 1, 1);

    load(1, 8'h11, 1'b1); load(3, 8'h33, 1'b1);
    run_round(0, 0, 0, 0);

    for (int i = 0; i < N; i++) load(i, 8'(8'h50 + i), 1'b1);
    load(0, 8'h5F, 1'b1);
    run_round(0, 0, 0, 0);

    load(0, 8'hC0, 1'b0); load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b1);
    load(1, 8'hD0, 1'b1);
    run_round(0, 0, 0, 0);

    load(2, 8'hE2, 1'b1); load(3, 8'hE3, 1'b1);
    run_round(0, 1, 0, 0);

    // Withdraw: requester 1 drops its byte while the transmitter is held busy.
    wait_idle();
    @(negedge clk) stall_req = 1;
    repeat (2) @(posedge clk);
    s0 = n_starts; r0 = n_ready;
    @(negedge clk);
    load(1, 8'h77, 1'b1);
    tail[1] = ntail[1];
    repeat (3) @(posedge clk);
    @(negedge clk) en[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tail[1] = tail[1] - 1; ntail[1] = tail[1];
    en[1] = 1; stall_req = 0;
    repeat (20) @(posedge clk);
    #2;
    chk("withdraw_no_start", n_starts - s0, 0);
    chk("withdraw_no_ready", n_ready - r0, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(2);
        for (int p = 0; p < np; p++) begin
          nbytes = $urandom_range(3, 1);
          for (int b = 0; b < nbytes; b++) load(i, 8'($urandom()), b == nbytes - 1);
        end
      end
      run_round(12, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
